// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation encodings, issue FSM states, the sign
// mask, the default adder latency and the operand sign transformation that
// both the fadd and fmul issue blocks use.
package fpu_pkg;

    // Pipeline depth of the fadd instance: cycles from seeing fa_ready to
    // fa_y/fa_ovf being valid.
    localparam int unsigned FADD_LAT  = 3;
    localparam logic [31:0] SIGN_MASK = 32'h8000_0000;

    typedef enum logic [1:0] {
        FOP_ADD  = 2'b00,   // a + b
        FOP_SUB  = 2'b01,   // a - b
        FOP_RSUB = 2'b10,   // b - a
        FOP_NADD = 2'b11    // -a - b
    } fop_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } fstate_e;

    typedef struct packed {
        logic [31:0] x1;
        logic [31:0] x2;
    } fop_pair_t;

    // Map an operation onto a plain addition by flipping sign bits only.
    // Exponent and mantissa are untouched, so NaN payloads and infinities
    // reach the adder unchanged apart from their sign.
    function automatic fop_pair_t sign_xform(input fop_e        op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        fop_pair_t p;
        case (op)
            FOP_ADD: begin
                p.x1 = a;
                p.x2 = b;
            end
            FOP_SUB: begin
                p.x1 = a;
                p.x2 = b ^ SIGN_MASK;
            end
            FOP_RSUB: begin
                p.x1 = b;
                p.x2 = a ^ SIGN_MASK;
            end
            default: begin
                p.x1 = a ^ SIGN_MASK;
                p.x2 = b ^ SIGN_MASK;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/fpu_issue.sv
// fpu_issue: initiator side of the fadd handshake.
// Accepts one request at a time, presents sign-adjusted operands to the
// adder, pulses fa_ready for one cycle, waits out the adder latency, then
// holds the result on a valid/ready response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_op, req_a, req_b     operation and IEEE-754 single operands
//   resp_valid/resp_ready    response handshake with backpressure
//   resp_y, resp_ovf         captured adder result and overflow flag
//   fa_x1, fa_x2, fa_ready   operands and start strobe toward the adder
//   fa_y, fa_ovf             adder outputs
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int unsigned LAT = FADD_LAT   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_y,
    output logic        resp_ovf,

    output logic [31:0] fa_x1,
    output logic [31:0] fa_x2,
    output logic        fa_ready,
    input  logic [31:0] fa_y,
    input  logic        fa_ovf
);

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    fstate_e     state_q;
    logic        req_rdy_q;
    logic        resp_valid_q;
    logic        fa_ready_q;
    logic [31:0] resp_y_q;
    logic        resp_ovf_q;
    logic [31:0] x1_q, x2_q;
    logic [3:0]  cnt_q;

    fop_pair_t   ops_d;

    assign ops_d = sign_xform(fop_e'(req_op), req_a, req_b);

    // req_rdy_q comes out of reset set so the block is ready in the first
    // cycle after reset; masking with rst keeps it low during reset itself.
    assign req_ready  = req_rdy_q & ~rst;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign resp_ovf   = resp_ovf_q;
    // The adder resamples its inputs every cycle once started, so these
    // come straight from registers that only load on acceptance.
    assign fa_x1      = x1_q;
    assign fa_x2      = x2_q;
    assign fa_ready   = fa_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_rdy_q    <= 1'b1;
            resp_valid_q <= 1'b0;
            fa_ready_q   <= 1'b0;
            resp_y_q     <= '0;
            resp_ovf_q   <= 1'b0;
            x1_q         <= '0;
            x2_q         <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_rdy_q) begin
                        x1_q       <= ops_d.x1;
                        x2_q       <= ops_d.x2;
                        req_rdy_q  <= 1'b0;
                        fa_ready_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // fa_ready was high for this single cycle; the adder
                    // sees it at the edge leaving ISSUE.
                    fa_ready_q <= 1'b0;
                    cnt_q      <= CNT_LOAD;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        resp_y_q     <= fa_y;
                        resp_ovf_q   <= fa_ovf;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_rdy_q    <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_rdy_q    <= 1'b1;
                    resp_valid_q <= 1'b0;
                    fa_ready_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
